pong_score_ctrl: RTL

Match controller that sits directly downstream of the two-player playfield. It consumes the playfield's per-player miss flags and keeps BCD scores for both players. It sequences serve, play and game-over by driving the playfield's reset. It optionally drives a 4-digit multiplexed seven-segment display with the score.

---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_score_ctrl_seg_mux.sv | 53 +++++
 rtl/pong_score_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong match controller: state encoding,
// BCD digit type, winner codes and the active-low seven-segment decode table.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    typedef logic [3:0] bcd_t;

    typedef logic [1:0] winner_t;
    localparam winner_t WIN_NONE = 2'b00;
    localparam winner_t WIN_P1   = 2'b01;
    localparam winner_t WIN_P2   = 2'b10;

    // Index = digit value; bit 0 = segment a ... bit 6 = segment g; codes 10..15 blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        bcd_t tens;
        bcd_t units;
        tens  = v[7:4];
        units = v[3:0];
        if (units == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/pong_score_ctrl_seg_mux.sv
// Four-digit multiplexed seven-segment driver for the two BCD scores.
// Only built when SCORE_SEG_EN is defined.
`ifdef SCORE_SEG_EN
module seg_mux
    import pong_pkg::*;
#(
    parameter int unsigned SEG_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    output logic [6:0] seg,
    output logic [3:0] an
);

    logic [SEG_DIV-1:0] refresh_q;
    logic [1:0]         sel;
    bcd_t               digit;
    logic [3:0]         an_d;
    logic [6:0]         seg_q;
    logic [3:0]         an_q;

    assign sel = refresh_q[SEG_DIV-1 -: 2];

    always_comb begin
        digit = score2[3:0];
        an_d  = 4'b1110;
        case (sel)
            2'd0: begin digit = score2[3:0]; an_d = 4'b1110; end
            2'd1: begin digit = score2[7:4]; an_d = 4'b1101; end
            2'd2: begin digit = score1[3:0]; an_d = 4'b1011; end
            default: begin digit = score1[7:4]; an_d = 4'b0111; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_q <= '0;
            seg_q     <= '1;
            an_q      <= '1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            seg_q     <= SEG_LUT[digit];
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
`endif

// File: rtl/pong_score_ctrl.sv
// Pong match controller: BCD scoring, serve/play/game-over sequencing and
// playfield reset. Define SCORE_SEG_EN to add the seven-segment score display.
module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned SEG_DIV      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       miss1,
    input  logic       miss2,
    output logic       field_rst,
    output logic [7:0] score1,
    output logic [7:0] score2,
    output logic [1:0] winner,
    output logic [1:0] state
`ifdef SCORE_SEG_EN
    ,
    output logic [6:0] seg,
    output logic [3:0] an
`endif
);

    localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
    localparam logic [6:0] WIN_N   = 7'(WIN_SCORE);

    state_e     state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [6:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [7:0] bcd1_q, bcd1_d, bcd2_q, bcd2_d;
    winner_t    winner_q, winner_d;
    logic       field_rst_q;
    logic       start_prev_q, miss1_prev_q, miss2_prev_q;

    logic       start_e, miss1_e, miss2_e;
    logic [7:0] frame_inc;
    logic [6:0] cnt1_inc, cnt2_inc;

    assign start_e   = start & ~start_prev_q;
    assign miss1_e   = miss1 & ~miss1_prev_q;
    assign miss2_e   = miss2 & ~miss2_prev_q;
    assign frame_inc = frame_cnt_q + 8'd1;
    assign cnt1_inc  = cnt1_q + 7'd1;
    assign cnt2_inc  = cnt2_q + 7'd1;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        cnt1_d      = cnt1_q;
        cnt2_d      = cnt2_q;
        bcd1_d      = bcd1_q;
        bcd2_d      = bcd2_q;
        winner_d    = winner_q;
        case (state_q)
            ST_IDLE: begin
                if (start_e) begin
                    state_d     = ST_SERVE;
                    frame_cnt_d = '0;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_inc;
                    if (frame_inc == SERVE_N) state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Every exit from PLAY re-arms the serve counter for the next rally.
                frame_cnt_d = '0;
                if (miss1_e && miss2_e) begin
                    state_d = ST_SERVE;
                end else if (miss1_e) begin
                    cnt2_d = cnt2_inc;
                    bcd2_d = bcd_inc(bcd2_q);
                    if (cnt2_inc == WIN_N) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P2;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else if (miss2_e) begin
                    cnt1_d = cnt1_inc;
                    bcd1_d = bcd_inc(bcd1_q);
                    if (cnt1_inc == WIN_N) begin
                        state_d  = ST_OVER;
                        winner_d = WIN_P1;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end
            end
            ST_OVER: begin
                if (start_e) begin
                    state_d     = ST_SERVE;
                    frame_cnt_d = '0;
                    cnt1_d      = '0;
                    cnt2_d      = '0;
                    bcd1_d      = '0;
                    bcd2_d      = '0;
                    winner_d    = WIN_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            bcd1_q       <= '0;
            bcd2_q       <= '0;
            winner_q     <= WIN_NONE;
            field_rst_q  <= 1'b1;
            start_prev_q <= 1'b0;
            miss1_prev_q <= 1'b0;
            miss2_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            bcd1_q       <= bcd1_d;
            bcd2_q       <= bcd2_d;
            winner_q     <= winner_d;
            field_rst_q  <= (state_d != ST_PLAY);
            start_prev_q <= start;
            miss1_prev_q <= miss1;
            miss2_prev_q <= miss2;
        end
    end

    assign field_rst = field_rst_q;
    assign score1    = bcd1_q;
    assign score2    = bcd2_q;
    assign winner    = winner_q;
    assign state     = state_q;

`ifdef SCORE_SEG_EN
    seg_mux #(
        .SEG_DIV(SEG_DIV)
    ) u_seg_mux (
        .clk   (clk),
        .reset (reset),
        .score1(bcd1_q),
        .score2(bcd2_q),
        .seg   (seg),
        .an    (an)
    );
`else
    // Display divider is meaningless without the display; keep it referenced.
    if (SEG_DIV < 2) begin : g_seg_div_unused
    end
`endif

endmodule
